// File: rtl/whack_pkg.sv
// -----------------------------------------------------------------------------
// whack_pkg
// Shared definitions for the whack-a-mole game blocks.
//   RAND_W        : width of the prbs16 output word
//   LIVES_DEFAULT : default lives per game
//   state_t       : game FSM encodings (3 bits)
//   max_int       : helper for deriving counter widths from parameters
// -----------------------------------------------------------------------------
package whack_pkg;

  localparam int RAND_W        = 16;
  localparam int LIVES_DEFAULT = 3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DRAW = 3'd1,
    ST_WAIT = 3'd2,
    ST_UP   = 3'd3,
    ST_OVER = 3'd4
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_edge_detect.sv
// -----------------------------------------------------------------------------
// btn_edge_detect
// Registers a vector of already-debounced buttons and flags rising edges.
// Ports:
//   clk   in  1  system clock
//   rst   in  1  synchronous, active-low reset (clears the history)
//   btn   in  W  button levels, active-high
//   rise  out W  btn & ~previous btn (combinational from the current level)
// -----------------------------------------------------------------------------
module btn_edge_detect #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] btn,
  output logic [W-1:0] rise
);

  logic [W-1:0] btn_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!rst) btn_q <= '0;
    else      btn_q <= btn;
  end

  assign rise = btn & ~btn_q;

endmodule

// File: rtl/mole_scheduler.sv
// -----------------------------------------------------------------------------
// mole_scheduler
// Game-control stage behind prbs16: picks the hole and pre-appearance delay
// from the random word, times the mole, judges hits/misses, keeps score and
// lives, and pulses prbs_shift_en so each random word is consumed once.
//
// Ports:
//   clk           in  1          system clock
//   rst           in  1          synchronous, active-low reset
//   start         in  1          level; starts/restarts a game from IDLE/OVER
//   btn           in  NUM_HOLES  debounced player buttons, active-high
//   rand_in       in  RAND_W     outSeq from prbs16
//   prbs_shift_en out 1          shiftEn to prbs16 (IDLE and DRAW only)
//   mole          out NUM_HOLES  one-hot visible mole, zero when hidden
//   hit_pulse     out 1          one-cycle pulse on a hit
//   miss_pulse    out 1          one-cycle pulse on a timeout
//   score         out SCORE_W    hits this game, saturating
//   lives         out 3          remaining lives
//   game_over     out 1          high in OVER
//
// Build option: MOLE_NO_REPEAT_EN -- when defined, a drawn hole equal to the
// previous hole of the same game is bumped to the next hole (mod NUM_HOLES).
// -----------------------------------------------------------------------------
module mole_scheduler
  import whack_pkg::*;
#(
  parameter int HOLE_BITS  = 3,
  parameter int DELAY_BITS = 4,
  parameter int DELAY_MIN  = 4,
  parameter int UP_TIME    = 16,
  parameter int SCORE_W    = 8,
  parameter int LIVES      = LIVES_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [2**HOLE_BITS-1:0] btn,
  input  logic [RAND_W-1:0]       rand_in,
  output logic                    prbs_shift_en,
  output logic [2**HOLE_BITS-1:0] mole,
  output logic                    hit_pulse,
  output logic                    miss_pulse,
  output logic [SCORE_W-1:0]      score,
  output logic [2:0]              lives,
  output logic                    game_over
);

  localparam int NUM_HOLES = 2**HOLE_BITS;
  // Counter must hold both the longest WAIT load and UP_TIME-1.
  localparam int CNT_W = max_int(max_int($clog2(DELAY_MIN + 2**DELAY_BITS),
                                         $clog2(UP_TIME)), 1);

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic [HOLE_BITS-1:0]   hole, hole_nxt;
  logic [SCORE_W-1:0]     score_nxt;
  logic [2:0]             lives_nxt;
  logic [NUM_HOLES-1:0]   mole_nxt;
  logic                   hit_nxt, miss_nxt;
  logic                   shift_int;
  logic [NUM_HOLES-1:0]   btn_rise;
  logic [HOLE_BITS-1:0]   cand;
  logic                   unused_rand;

`ifdef MOLE_NO_REPEAT_EN
  logic first_draw, first_draw_nxt;
`endif

  // Only the hole and delay fields of the random word are consumed.
  assign unused_rand = ^rand_in;

  btn_edge_detect #(.W(NUM_HOLES)) u_btn_edge (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn),
    .rise (btn_rise)
  );

  // Hole candidate for the next DRAW.
  always_comb begin
    cand = rand_in[HOLE_BITS-1:0];
`ifdef MOLE_NO_REPEAT_EN
    // Incrementing the HOLE_BITS-wide value wraps the top hole to hole 0.
    if (!first_draw && cand == hole) cand = cand + 1'b1;
`endif
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    hole_nxt  = hole;
    score_nxt = score;
    lives_nxt = lives;
    hit_nxt   = 1'b0;
    miss_nxt  = 1'b0;
    shift_int = 1'b0;
`ifdef MOLE_NO_REPEAT_EN
    first_draw_nxt = first_draw;
`endif

    case (state)
      ST_IDLE, ST_OVER: begin
        // prbs free-runs in IDLE so the start time perturbs the sequence.
        shift_int = (state == ST_IDLE);
        if (start) begin
          state_nxt = ST_DRAW;
          score_nxt = '0;
          lives_nxt = 3'(LIVES);
`ifdef MOLE_NO_REPEAT_EN
          first_draw_nxt = 1'b1;
`endif
        end
      end

      ST_DRAW: begin
        shift_int = 1'b1;
        hole_nxt  = cand;
        cnt_nxt   = CNT_W'(DELAY_MIN) + CNT_W'(rand_in[HOLE_BITS +: DELAY_BITS]);
        state_nxt = ST_WAIT;
`ifdef MOLE_NO_REPEAT_EN
        first_draw_nxt = 1'b0;
`endif
      end

      ST_WAIT: begin
        if (cnt == '0) begin
          state_nxt = ST_UP;
          cnt_nxt   = CNT_W'(UP_TIME - 1);
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end

      ST_UP: begin
        // A hit on the expiry cycle takes priority over the timeout.
        if (btn_rise[hole]) begin
          hit_nxt   = 1'b1;
          score_nxt = (&score) ? score : score + 1'b1;
          state_nxt = ST_DRAW;
        end else if (cnt == '0) begin
          miss_nxt  = 1'b1;
          lives_nxt = lives - 1'b1;
          state_nxt = (lives == 3'd1) ? ST_OVER : ST_DRAW;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  // Registered mole: lit on the same edge that enters UP.
  always_comb begin
    mole_nxt = '0;
    if (state_nxt == ST_UP) mole_nxt[hole_nxt] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      hole       <= '0;
      score      <= '0;
      lives      <= '0;
      mole       <= '0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      hole       <= hole_nxt;
      score      <= score_nxt;
      lives      <= lives_nxt;
      mole       <= mole_nxt;
      hit_pulse  <= hit_nxt;
      miss_pulse <= miss_nxt;
    end
  end

`ifdef MOLE_NO_REPEAT_EN
  always_ff @(posedge clk) begin
    if (!rst) first_draw <= 1'b1;
    else      first_draw <= first_draw_nxt;
  end
`endif

  assign prbs_shift_en = rst & shift_int;
  assign game_over     = (state == ST_OVER);

endmodule

// File: tb/tb_mole_scheduler.sv
// -----------------------------------------------------------------------------
// tb_mole_scheduler
// Directed bench for mole_scheduler with default parameters. Stimulus pushes
// expected events (mole onset, hit, miss) with their absolute cycle into a
// scoreboard; a negedge monitor pops and compares whenever the DUT shows one.
// -----------------------------------------------------------------------------
module tb_mole_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  btn;
  logic [15:0] rand_in;
  logic        prbs_shift_en;
  logic [7:0]  mole;
  logic        hit_pulse;
  logic        miss_pulse;
  logic [7:0]  score;
  logic [2:0]  lives;
  logic        game_over;

  mole_scheduler dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .btn           (btn),
    .rand_in       (rand_in),
    .prbs_shift_en (prbs_shift_en),
    .mole          (mole),
    .hit_pulse     (hit_pulse),
    .miss_pulse    (miss_pulse),
    .score         (score),
    .lives         (lives),
    .game_over     (game_over)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

`ifdef MOLE_NO_REPEAT_EN
  localparam logic [7:0] SECOND_MOLE = 8'h01;
`else
  localparam logic [7:0] SECOND_MOLE = 8'h80;
`endif

  typedef enum int {EV_MOLE, EV_HIT, EV_MISS} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    int         cyc;
    logic [7:0] mole;
    logic [7:0] score;
    logic [2:0] lives;
    logic       go;
  } ev_t;

  ev_t sb[$];
  logic [7:0] mole_prev = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input ev_kind_t k, input int c, input logic [7:0] m,
                         input logic [7:0] s, input logic [2:0] l, input logic g);
    ev_t e;
    e.kind = k; e.cyc = c; e.mole = m; e.score = s; e.lives = l; e.go = g;
    sb.push_back(e);
  endtask

  task automatic compare_ev(input ev_kind_t k);
    ev_t e;
    bit  ok;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_%s at cycle %0d: scoreboard empty", k.name(), cyc);
      return;
    end
    e = sb.pop_front();
    tests++;
    ok = (e.kind == k) && (e.cyc == cyc);
    case (k)
      EV_MOLE: ok = ok && (mole == e.mole);
      EV_HIT:  ok = ok && (score == e.score) && (lives == e.lives) && (mole == 8'h00);
      default: ok = ok && (score == e.score) && (lives == e.lives) &&
                    (game_over == e.go) && (mole == 8'h00);
    endcase
    if (!ok) begin
      fails++;
      $display("FAIL ev_%s: got cyc=%0d mole=%h score=%0d lives=%0d go=%b; expected %s cyc=%0d mole=%h score=%0d lives=%0d go=%b",
               k.name(), cyc, mole, score, lives, game_over,
               e.kind.name(), e.cyc, e.mole, e.score, e.lives, e.go);
    end
  endtask

  // Monitor: one comparison per DUT event.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (mole != 8'h00 && mole_prev == 8'h00) compare_ev(EV_MOLE);
      if (hit_pulse)  compare_ev(EV_HIT);
      if (miss_pulse) compare_ev(EV_MISS);
    end
    mole_prev <= mole;
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic wait_mole(output int m);
    bit got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (mole != 8'h00) begin
        got = 1'b1;
        break;
      end
    end
    m = cyc;
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL wait_mole: no mole within 200 cycles (cycle %0d)", cyc);
    end
  endtask

  // Start a game: d is the expected WAIT load, h the expected hole.
  task automatic start_game(input logic [15:0] r, input int d, input int h);
    int c;
    rand_in = r;
    start   = 1'b1;
    c       = cyc;
    push_ev(EV_MOLE, c + 3 + d, 8'(1 << h), 8'h00, 3'd0, 1'b0);
    tick();
    start = 1'b0;
    check("draw_shift_en", prbs_shift_en, 1);
    check("start_score", score, 0);
    check("start_lives", lives, 3);
    check("start_game_over", game_over, 0);
    tick();
    check("wait_shift_en", prbs_shift_en, 0);
    check("wait_mole_off", mole, 0);
  endtask

  task automatic reset_mid_up;
    rst = 1'b0;
    tick();
    check("rst_mole", mole, 0);
    check("rst_score", score, 0);
    check("rst_lives", lives, 0);
    check("rst_shift_en", prbs_shift_en, 0);
    check("rst_game_over", game_over, 0);
    check("rst_pulses", {hit_pulse, miss_pulse}, 0);
    tick();
    rst = 1'b1;
    tick();
    check("idle_shift_en", prbs_shift_en, 1);
    check("idle_mole", mole, 0);
  endtask

  initial begin
    int m, k;
    rst     = 1'b0;
    start   = 1'b0;
    btn     = 8'h00;
    rand_in = 16'h0000;

    // Power-on reset.
    repeat (2) tick();
    check("por_shift_en", prbs_shift_en, 0);
    check("por_mole", mole, 0);
    check("por_score", score, 0);
    check("por_lives", lives, 0);
    rst = 1'b1;
    tick();
    check("por_idle_shift_en", prbs_shift_en, 1);

    // Hole 5, delay 4+2; hit on hole 5.
    start_game(16'h0015, 6, 5);
    wait_mole(m);
    tick();
    tick();
    btn[5] = 1'b1;
    k = cyc;
    push_ev(EV_HIT, k + 1, 8'h00, 8'd1, 3'd3, 1'b0);
    push_ev(EV_MOLE, k + 9, 8'h20, 8'h00, 3'd0, 1'b0);

    // btn[5] still held when the next mole rises: no hit. btn[2] ignored.
    wait_mole(m);
    btn[2] = 1'b1;
    tick();
    tick();
    btn[5] = 1'b0;
    btn[2] = 1'b0;
    tick();
    btn[5] = 1'b1;
    k = cyc;
    push_ev(EV_HIT, k + 1, 8'h00, 8'd2, 3'd3, 1'b0);
    push_ev(EV_MOLE, k + 9, 8'h20, 8'h00, 3'd0, 1'b0);
    tick();
    btn[5] = 1'b0;

    // Three timeouts end the game.
    for (int i = 1; i <= 3; i++) begin
      wait_mole(m);
      push_ev(EV_MISS, m + 16, 8'h00, 8'd2, 3'(3 - i), (i == 3));
      if (i < 3) push_ev(EV_MOLE, m + 24, 8'h20, 8'h00, 3'd0, 1'b0);
      repeat (17) tick();
    end
    check("over_game_over", game_over, 1);
    check("over_mole", mole, 0);
    check("over_shift_en", prbs_shift_en, 0);
    check("over_score_hold", score, 2);
    check("over_lives", lives, 0);

    // Restart from OVER; hit lands on the expiry cycle.
    start_game(16'h0015, 6, 5);
    wait_mole(m);
    repeat (15) tick();
    btn[5]  = 1'b1;
    rand_in = 16'h0000;
    push_ev(EV_HIT, m + 16, 8'h00, 8'd1, 3'd3, 1'b0);
    push_ev(EV_MOLE, m + 22, 8'h01, 8'h00, 3'd0, 1'b0);
    tick();
    btn[5] = 1'b0;

    // Drive score to saturation on hole 0 (delay 4).
    for (int s = 2; s <= 256; s++) begin
      wait_mole(m);
      btn[0] = 1'b1;
      push_ev(EV_HIT, m + 1, 8'h00, (s > 255) ? 8'hFF : 8'(s), 3'd3, 1'b0);
      push_ev(EV_MOLE, m + 7, 8'h01, 8'h00, 3'd0, 1'b0);
      tick();
      btn[0] = 1'b0;
    end
    wait_mole(m);
    check("score_saturated", score, 8'hFF);
    tick();
    reset_mid_up();

    // Two draws with hole field 7.
    start_game(16'h0007, 4, 7);
    wait_mole(m);
    tick();
    btn[7] = 1'b1;
    k = cyc;
    push_ev(EV_HIT, k + 1, 8'h00, 8'd1, 3'd3, 1'b0);
    push_ev(EV_MOLE, k + 7, SECOND_MOLE, 8'h00, 3'd0, 1'b0);
    tick();
    btn[7] = 1'b0;
    wait_mole(m);
    tick();
    reset_mid_up();

    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
